// File: rtl/iomem_periph_pkg.sv
// Shared constants, types and helpers for the iomem peripheral block.
package iomem_periph_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = 6;
   localparam int unsigned CTRL_W = 3;

   // Word offsets, i.e. iomem_addr[7:2]
   localparam logic [OFF_W-1:0] OFF_LED  = 6'h00;
   localparam logic [OFF_W-1:0] OFF_SW   = 6'h01;
   localparam logic [OFF_W-1:0] OFF_CNT  = 6'h02;
   localparam logic [OFF_W-1:0] OFF_CMP  = 6'h03;
   localparam logic [OFF_W-1:0] OFF_CTRL = 6'h04;
   localparam logic [OFF_W-1:0] OFF_STAT = 6'h05;

   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_AUTO_RELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN      = 2;
   localparam int unsigned STAT_MATCH       = 0;

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   typedef struct packed {
      logic              cnt_we;
      logic              cmp_we;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] data;
   } tmr_wr_t;

   // Replace only the strobed bytes of old_v with new_v
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] r;
      r = old_v;
      for (int unsigned b = 0; b < STRB_W; b++)
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/iomem_timer.sv
// 32-bit free-running timer with compare, sticky match flag and optional auto-reload.
module iomem_timer
   import iomem_periph_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  tmr_wr_t           wr,
   input  logic              en,
   input  logic              auto_reload,
   input  logic              match_clr,
   output logic [DATA_W-1:0] cnt,
   output logic [DATA_W-1:0] cmp,
   output logic              match,
   output logic [DATA_W-1:0] cnt_nxt_c,
   output logic [DATA_W-1:0] cmp_nxt_c,
   output logic              match_nxt_c
);

   logic hit_c;

   assign hit_c = en && (cnt == cmp);

   // Bus write beats increment/reload; a match set beats a W1C clear
   always_comb begin
      cnt_nxt_c = cnt;
      if (wr.cnt_we)
         cnt_nxt_c = merge_bytes(cnt, wr.data, wr.strb);
      else if (hit_c && auto_reload)
         cnt_nxt_c = '0;
      else if (en)
         cnt_nxt_c = cnt + 32'd1;
      cmp_nxt_c   = wr.cmp_we ? merge_bytes(cmp, wr.data, wr.strb) : cmp;
      match_nxt_c = hit_c | (match & ~match_clr);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         cmp   <= '1;
         match <= 1'b0;
      end else begin
         cnt   <= cnt_nxt_c;
         cmp   <= cmp_nxt_c;
         match <= match_nxt_c;
      end
   end

endmodule

// File: rtl/iomem_periph.sv
// iomem bus responder: LED register, synchronized switches and a compare timer
// in a 256-byte window, acknowledged with one wait state.
module iomem_periph
   import iomem_periph_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
   parameter int unsigned LED_W     = 8,
   parameter int unsigned SW_W      = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              iomem_valid,
   output logic              iomem_ready,
   input  logic [STRB_W-1:0] iomem_wstrb,
   input  logic [31:0]       iomem_addr,
   input  logic [DATA_W-1:0] iomem_wdata,
   output logic [DATA_W-1:0] iomem_rdata,
   output logic [LED_W-1:0]  leds,
   input  logic [SW_W-1:0]   switches,
   output logic              timer_irq
);

   state_t              state, state_nxt;
   logic                sel_c, acc_c, wr_c;
   logic [OFF_W-1:0]    off_c;
   logic [LED_W-1:0]    led_nxt_c;
   logic [CTRL_W-1:0]   ctrl, ctrl_nxt_c;
   logic [SW_W-1:0]     sw_meta, sw_sync;
   tmr_wr_t             tmr_wr_c;
   logic                match_clr_c;
   logic [DATA_W-1:0]   cnt, cmp, cnt_nxt_c, cmp_nxt_c, rd_c;
   logic                match, match_nxt_c;
   logic                unused_addr_lsb;

   assign sel_c           = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
   assign acc_c           = (state == ST_IDLE) && sel_c;
   assign wr_c            = acc_c && (iomem_wstrb != '0);
   assign off_c           = iomem_addr[7:2];
   assign unused_addr_lsb = ^iomem_addr[1:0];

   // Write decode
   always_comb begin
      led_nxt_c       = leds;
      ctrl_nxt_c      = ctrl;
      tmr_wr_c.cnt_we = wr_c && (off_c == OFF_CNT);
      tmr_wr_c.cmp_we = wr_c && (off_c == OFF_CMP);
      tmr_wr_c.strb   = iomem_wstrb;
      tmr_wr_c.data   = iomem_wdata;
      match_clr_c     = wr_c && (off_c == OFF_STAT) && iomem_wstrb[0] && iomem_wdata[STAT_MATCH];
      if (wr_c && (off_c == OFF_LED))
         led_nxt_c = LED_W'(merge_bytes(DATA_W'(leds), iomem_wdata, iomem_wstrb));
      if (wr_c && (off_c == OFF_CTRL))
         ctrl_nxt_c = CTRL_W'(merge_bytes(DATA_W'(ctrl), iomem_wdata, iomem_wstrb));
   end

   // Read mux returns post-write values on a write
   always_comb begin
      rd_c = '0;
      case (off_c)
         OFF_LED:  rd_c = DATA_W'(led_nxt_c);
         OFF_SW:   rd_c = DATA_W'(sw_sync);
         OFF_CNT:  rd_c = wr_c ? cnt_nxt_c : cnt;
         OFF_CMP:  rd_c = wr_c ? cmp_nxt_c : cmp;
         OFF_CTRL: rd_c = DATA_W'(ctrl_nxt_c);
         OFF_STAT: rd_c[STAT_MATCH] = wr_c ? match_nxt_c : match;
         default:  rd_c = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (sel_c) state_nxt = ST_ACK;
         ST_ACK:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         iomem_ready <= 1'b0;
         iomem_rdata <= '0;
         leds        <= '0;
         ctrl        <= '0;
         sw_meta     <= '0;
         sw_sync     <= '0;
         timer_irq   <= 1'b0;
      end else begin
         state       <= state_nxt;
         iomem_ready <= acc_c;
         iomem_rdata <= acc_c ? rd_c : '0;
         leds        <= led_nxt_c;
         ctrl        <= ctrl_nxt_c;
         sw_meta     <= switches;
         sw_sync     <= sw_meta;
         timer_irq   <= match_nxt_c & ctrl_nxt_c[CTRL_IRQ_EN];
      end
   end

   iomem_timer u_timer (
      .clk         (clk),
      .resetn      (resetn),
      .wr          (tmr_wr_c),
      .en          (ctrl[CTRL_EN]),
      .auto_reload (ctrl[CTRL_AUTO_RELOAD]),
      .match_clr   (match_clr_c),
      .cnt         (cnt),
      .cmp         (cmp),
      .match       (match),
      .cnt_nxt_c   (cnt_nxt_c),
      .cmp_nxt_c   (cmp_nxt_c),
      .match_nxt_c (match_nxt_c)
   );

endmodule
